sprite_cmd_queue: RTL and testbench
===================================

# sprite_cmd_queue

Parametrised command queue between the command decoder and the sprite engine. Replaces the fixed 43-bit sprite command FIFO. Adds:
- configurable width and depth, with all DEPTH entries usable;
- an occupancy count and an almost-full watermark;
- synchronous flush;
- read-while-full;
- sticky overflow/underflow error flags.

Output is first-word-fall-through: the head entry is always presented on `rd_data`.

## Interface
Parameters:
- `WIDTH`, 43, command word width in bits (≥1)
- `DEPTH`, 16, number of entries; power of two, ≥2
- `AFULL_THRESH`, 14, `almost_full` asserts when count ≥ this value; range 1..DEPTH

Ports. Clock and reset are fixed: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  synchronous clear of all queue contents
- `wr_en`  in  1  write request
- `wr_data`  in  WIDTH  command word to enqueue
- `rd_en`  in  1  pop request for the head entry
- `rd_data`  out  WIDTH  head entry; 0 when empty
- `empty`  out  1  count == 0
- `full`  out  1  count == DEPTH
- `almost_full`  out  1  count ≥ AFULL_THRESH
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `overflow`  out  1  sticky: a write was rejected
- `underflow`  out  1  sticky: a read was rejected
- `clr_err`  in  1  clears `overflow` and `underflow`

## Operation
Storage:
- DEPTH × WIDTH array; storage is not reset.
- `rd_ptr` and `wr_ptr` are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- `count` is a separate register. Full/empty derive only from `count`, never from pointer comparison.

Acceptance, evaluated from current-cycle state:
- Read accepted: `rd_acc = rd_en && !empty && !flush`.
- Write accepted: `wr_acc = wr_en && !flush && (!full || rd_acc)`. Read-while-full is allowed: the slot freed by the pop is refilled in the same cycle.
- No bypass. When the queue is empty and `wr_en`/`rd_en` arrive together, the write is accepted and the read is rejected (sets `underflow`).

Updates at the clock edge:
- `wr_acc`: `mem[wr_ptr] <= wr_data`; `wr_ptr` increments.
- `rd_acc`: `rd_ptr` increments.
- `count`: +1 when `wr_acc` only; −1 when `rd_acc` only; unchanged when both or neither.

Flush has highest priority below reset:
- Next state: `rd_ptr`, `wr_ptr` and `count` are 0.
- Neither request is accepted in the flush cycle.
- Error flags are not set by requests in the flush cycle.

Error flags:
- `overflow` sets when `wr_en && !flush && !wr_acc`.
- `underflow` sets when `rd_en && !flush && !rd_acc`.
- Both are sticky until `clr_err`. If `clr_err` and a new error occur in the same cycle, set wins.
- Flush does not clear the flags.

Outputs:
- `rd_data = empty ? 0 : mem[rd_ptr]`, combinational from registered state.
- `empty`, `full` and `almost_full` are combinational decodes of the `count` register.

## Timing
Reset values, asynchronous on `rst` high:
- `count`=0, pointers=0, `empty`=1, `full`=0, `almost_full`=0, `overflow`=0, `underflow`=0, `rd_data`=0.

Latencies:
- Write-to-visible: a word written at edge N appears on `rd_data` (with `empty`=0) in the cycle after edge N, when the queue was empty.
- Pop: `rd_en` at edge N advances `rd_data` to the next entry after edge N. The consumer samples `rd_data` in the same cycle it asserts `rd_en`.

Other timing rules:
- Flags and `count` change only at clock edges or on asynchronous reset.
- `rst` asserted mid-operation discards all contents immediately. The first write after deassertion lands in entry 0.
- Wrap-around: after DEPTH writes and DEPTH reads, ordering is preserved across the pointer wrap.
- Depth-1 corner: at count == DEPTH-1, a single write sets `full` next cycle; a simultaneous write and read keeps count at DEPTH-1.

## Test plan
1. Reset, then write 0x1..0x10 (DEPTH=16) on consecutive cycles with no reads. Required: `count` reaches 16; `full`=1; `almost_full` asserts after the 14th write; a 17th write sets `overflow` and leaves `count`=16 and `rd_data`=0x1.
2. Full queue, then `wr_en` and `rd_en` together with `wr_data`=0xAA. Required: `count` stays 16; `rd_data` becomes 0x2; `overflow` not set; draining 16 entries yields 0x2..0x10 then 0xAA.
3. Empty queue, `wr_en` and `rd_en` together with `wr_data`=0x55. Required: `underflow`=1; `count`=1; `rd_data`=0x55 next cycle. Then `clr_err` alone clears `underflow` the following cycle.
4. Queue holding 5 entries, `flush` together with `wr_en` and `rd_en`. Required: next cycle `count`=0, `empty`=1, `rd_data`=0; no error flag set; the next write appears at `rd_data` one cycle later.
5. Stream 40 random words with random `wr_en`/`rd_en`, including pointer wrap. Required: scoreboard order matches exactly, `count` always equals writes − reads, and no error flags set when requests honour `full`/`empty`.
6. Assert `rst` mid-stream with 7 entries queued. Required: outputs take reset values immediately, without waiting for a clock edge; after release, a write of 0x3C reads back as 0x3C.

Source files
------------

// File: rtl/sprite_cmd_queue.sv
// sprite_cmd_queue
//   Command queue between the command decoder and the sprite engine.
//   First-word-fall-through: the head entry is always driven on rd_data
//   (0 when empty). Occupancy is tracked in a dedicated count register;
//   full/empty/almost_full decode from it, never from pointer compares.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   flush              synchronous clear of pointers and count
//   wr_en, wr_data     enqueue request / word
//   rd_en              pop request for the head entry
//   rd_data            head entry, 0 when empty
//   empty/full         count == 0 / count == DEPTH
//   almost_full        count >= AFULL_THRESH
//   count              occupancy 0..DEPTH
//   overflow/underflow sticky rejected-write / rejected-read flags
//   clr_err            clears both sticky flags (a new error in the same cycle wins)
module sprite_cmd_queue #(
  parameter int WIDTH        = 43,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             rd_acc, wr_acc;
  logic             ovf_ev, unf_ev;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AFULL_THRESH));

  // No bypass: a read on an empty queue is rejected even if a write lands.
  // A pop frees a slot, so a full queue may accept a write in the same cycle.
  assign rd_acc = rd_en && !empty && !flush;
  assign wr_acc = wr_en && !flush && (!full || rd_acc);
  assign ovf_ev = wr_en && !flush && !wr_acc;
  assign unf_ev = rd_en && !flush && !rd_acc;

  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; pointers/count make stale words invisible.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; set takes priority over clr_err. Flush leaves them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  && !clr_err) || ovf_ev;
      underflow <= (underflow && !clr_err) || unf_ev;
    end
  end

endmodule

// File: tb/tb_sprite_cmd_queue.sv
// Directed bench for sprite_cmd_queue (WIDTH=43, DEPTH=16, AFULL_THRESH=14).
module tb_sprite_cmd_queue;
  localparam int W = 43;
  localparam int D = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic [W-1:0]  rd_data;
  logic          empty, full, almost_full, overflow, underflow;
  logic [4:0]    count;

  int vecs = 0;
  int errs = 0;

  sprite_cmd_queue #(.WIDTH(W), .DEPTH(D), .AFULL_THRESH(14)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample/drive 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] q[$];
  logic [W-1:0] exp_w;
  bit           we, re;
  int           nwr, cyc;

  initial begin
    // ---- reset values (asynchronous, before any clock edge)
    #1 rst = 1'b1;
    #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_full", 64'(full), 0);
    chk("rst_afull", 64'(almost_full), 0);
    chk("rst_ovf", 64'(overflow), 0);
    chk("rst_unf", 64'(underflow), 0);
    chk("rst_rdata", 64'(rd_data), 0);
    step();
    rst = 1'b0;
    step();

    // ---- 1: fill 0x1..0x10, then overflow
    for (int i = 1; i <= D; i++) begin
      wr_en = 1'b1; wr_data = W'(i);
      step();
      chk("fill_count", 64'(count), 64'(i));
      chk("fill_afull", 64'(almost_full), 64'(i >= 14));
      chk("fill_full", 64'(full), 64'(i == D));
    end
    wr_data = W'(64'h99);
    step();
    wr_en = 1'b0;
    chk("ovf_set", 64'(overflow), 1);
    chk("ovf_count", 64'(count), 16);
    chk("ovf_head", 64'(rd_data), 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("ovf_clr", 64'(overflow), 0);

    // ---- 2: read-while-full
    wr_en = 1'b1; rd_en = 1'b1; wr_data = W'(64'hAA);
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rwf_count", 64'(count), 16);
    chk("rwf_head", 64'(rd_data), 2);
    chk("rwf_ovf", 64'(overflow), 0);
    for (int i = 0; i < D; i++) begin
      exp_w = (i < 15) ? W'(i + 2) : W'(64'hAA);
      chk("drain_data", 64'(rd_data), 64'(exp_w));
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    chk("drain_empty", 64'(empty), 1);
    chk("drain_rdata0", 64'(rd_data), 0);
    chk("drain_unf", 64'(underflow), 0);

    // ---- 3: write+read on empty: no bypass
    wr_en = 1'b1; rd_en = 1'b1; wr_data = W'(64'h55);
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("nb_unf", 64'(underflow), 1);
    chk("nb_count", 64'(count), 1);
    chk("nb_head", 64'(rd_data), 64'h55);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("nb_clr", 64'(underflow), 0);
    chk("nb_count2", 64'(count), 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("nb_empty", 64'(empty), 1);

    // ---- 4: flush with concurrent requests
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = W'(64'h10 + i);
      step();
    end
    wr_en = 1'b0;
    chk("fl_pre", 64'(count), 5);
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = W'(64'h77);
    step();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("fl_count", 64'(count), 0);
    chk("fl_empty", 64'(empty), 1);
    chk("fl_rdata", 64'(rd_data), 0);
    chk("fl_ovf", 64'(overflow), 0);
    chk("fl_unf", 64'(underflow), 0);
    wr_en = 1'b1; wr_data = W'(64'h66);
    step();
    wr_en = 1'b0;
    chk("fl_next", 64'(rd_data), 64'h66);
    chk("fl_next_cnt", 64'(count), 1);

    // ---- depth-1 corner: fill to 15, then write+read holds 15
    for (int i = 0; i < 14; i++) begin
      wr_en = 1'b1; wr_data = W'(64'h100 + i);
      step();
    end
    wr_en = 1'b0;
    chk("d1_count", 64'(count), 15);
    chk("d1_notfull", 64'(full), 0);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = W'(64'h1FF);
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("d1_hold", 64'(count), 15);
    chk("d1_head", 64'(rd_data), 64'h100);
    flush = 1'b1;
    step();
    flush = 1'b0;

    // ---- 5: random stream honouring full/empty, scoreboard check
    q.delete();
    nwr = 0; cyc = 0;
    while (nwr < 40 && cyc < 2000) begin
      we = ($urandom_range(3) != 0) && (q.size() < D);
      re = ($urandom_range(1) != 0) && (q.size() > 0);
      exp_w = W'({$urandom(), $urandom()});
      wr_en = we; rd_en = re; wr_data = exp_w;
      if (re) chk("rnd_data", 64'(rd_data), 64'(q[0]));
      step();
      if (re) void'(q.pop_front());
      if (we) begin q.push_back(exp_w); nwr++; end
      chk("rnd_count", 64'(count), 64'(q.size()));
      cyc++;
    end
    chk("rnd_done", 64'(nwr), 40);
    wr_en = 1'b0;
    cyc = 0;
    while (q.size() > 0 && cyc < 100) begin
      rd_en = 1'b1;
      chk("rnd_drain", 64'(rd_data), 64'(q[0]));
      step();
      void'(q.pop_front());
      cyc++;
    end
    rd_en = 1'b0;
    chk("rnd_empty", 64'(empty), 1);
    chk("rnd_ovf", 64'(overflow), 0);
    chk("rnd_unf", 64'(underflow), 0);

    // ---- 6: asynchronous reset mid-stream
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("ar_unf_pre", 64'(underflow), 1);
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1; wr_data = W'(64'h20 + i);
      step();
    end
    wr_en = 1'b0;
    chk("ar_pre", 64'(count), 7);
    #1 rst = 1'b1;
    #1;
    chk("ar_count", 64'(count), 0);
    chk("ar_empty", 64'(empty), 1);
    chk("ar_rdata", 64'(rd_data), 0);
    chk("ar_unf", 64'(underflow), 0);
    step();
    rst = 1'b0;
    wr_en = 1'b1; wr_data = W'(64'h3C);
    step();
    wr_en = 1'b0;
    chk("ar_post", 64'(rd_data), 64'h3C);
    chk("ar_post_cnt", 64'(count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
